// File: rtl/mem_wb_stage_if.sv
// EX/MEM-to-writeback bundle: instruction from EX, data-memory read port and
// register-file writeback controls. The stage uses the slave view.
interface mem_wb_stage_if;
  logic        valid_i;
  logic        flush_i;
  logic        regWrite_i;
  logic        memToReg_i;
  logic        link_i;
  logic [5:0]  aluCtrl_i;
  logic [4:0]  writeReg_i;
  logic [31:0] aluResult_i;
  logic [31:0] linkAddr_i;
  logic        memReq_o;
  logic [31:0] memAddr_o;
  logic [31:0] memRdata_i;
  logic        memRdy_i;
  logic        stall_o;
  logic        regWrite3_o;
  logic [4:0]  writeReg_o;
  logic [31:0] writeData_o;
  logic        link3_o;
  logic [1:0]  lwxCtrl_o;
  logic        addrErr_o;

  modport slave (
    input  valid_i, flush_i, regWrite_i, memToReg_i, link_i, aluCtrl_i,
           writeReg_i, aluResult_i, linkAddr_i, memRdata_i, memRdy_i,
    output memReq_o, memAddr_o, stall_o, regWrite3_o, writeReg_o,
           writeData_o, link3_o, lwxCtrl_o, addrErr_o
  );

  modport master (
    output valid_i, flush_i, regWrite_i, memToReg_i, link_i, aluCtrl_i,
           writeReg_i, aluResult_i, linkAddr_i, memRdata_i, memRdy_i,
    input  memReq_o, memAddr_o, stall_o, regWrite3_o, writeReg_o,
           writeData_o, link3_o, lwxCtrl_o, addrErr_o
  );
endinterface

// File: rtl/mem_wb_stage.sv
// MIPS memory-access / writeback stage: issues load reads, extracts and extends
// load data, and presents one-cycle registered writeback controls.
//   state    | meaning
//   IDLE     | no load outstanding; non-loads write back directly
//   WAIT_MEM | load issued, memReq_o held until memRdy_i
module mem_wb_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input logic          clk,
  input logic          rst_n,
  mem_wb_stage_if.slave bus
);
  localparam logic [5:0] OP_LB  = 6'b100001;
  localparam logic [5:0] OP_LBU = 6'b101010;
  localparam logic [5:0] OP_LH  = 6'b101011;
  localparam logic [5:0] OP_LHU = 6'b101100;
  localparam logic [5:0] OP_LWL = 6'b101101;
  localparam logic [5:0] OP_LWR = 6'b101110;

  typedef enum logic {IDLE = 1'b0, WAIT_MEM = 1'b1} state_t;

  state_t      r_state;
  logic        r_mem_req;
  logic [31:0] r_mem_addr;
  logic [5:0]  r_op;
  logic [1:0]  r_off;
  logic [4:0]  r_dest;
  logic        r_ld_we;
  logic        r_wb_we;
  logic        r_wb_link;
  logic        r_wb_err;
  logic [4:0]  r_wb_reg;
  logic [31:0] r_wb_data;
  logic [1:0]  r_wb_lwx;
  logic        r_pend_v;
  logic        r_pend_we;
  logic        r_pend_link;
  logic [4:0]  r_pend_reg;
  logic [31:0] r_pend_data;

  logic        w_stall;
  logic        w_accept;
  logic        w_acc_load;
  logic        w_acc_alu;
  logic        w_load_done;
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [31:0] w_ext;
  logic        w_mis;
  logic [1:0]  w_lwx;
  logic        w_alu_we;
  logic [4:0]  w_alu_reg;
  logic [31:0] w_alu_data;

  assign w_stall     = (r_state == WAIT_MEM) && !bus.memRdy_i;
  assign w_accept    = bus.valid_i && !bus.flush_i && !w_stall;
  assign w_acc_load  = w_accept && bus.memToReg_i;
  assign w_acc_alu   = w_accept && !bus.memToReg_i;
  assign w_load_done = (r_state == WAIT_MEM) && bus.memRdy_i;

  assign w_alu_we   = bus.link_i || (bus.regWrite_i && (bus.writeReg_i != 5'd0));
  assign w_alu_reg  = bus.link_i ? 5'd31 : bus.writeReg_i;
  assign w_alu_data = bus.link_i ? bus.linkAddr_i + 32'd4 : bus.aluResult_i;

  // Big-endian lanes: byte offset 0 is the most significant byte.
  always_comb begin
    w_byte = bus.memRdata_i[31:24];
    case (r_off)
      2'd1:    w_byte = bus.memRdata_i[23:16];
      2'd2:    w_byte = bus.memRdata_i[15:8];
      2'd3:    w_byte = bus.memRdata_i[7:0];
      default: w_byte = bus.memRdata_i[31:24];
    endcase
    w_half = r_off[1] ? bus.memRdata_i[15:0] : bus.memRdata_i[31:16];
    w_ext  = bus.memRdata_i;
    w_mis  = 1'b0;
    w_lwx  = 2'd0;
    case (r_op)
      OP_LB:  w_ext = {{24{w_byte[7]}}, w_byte};
      OP_LBU: w_ext = {24'd0, w_byte};
      OP_LH: begin
        w_ext = {{16{w_half[15]}}, w_half};
        w_mis = r_off[0];
      end
      OP_LHU: begin
        w_ext = {16'd0, w_half};
        w_mis = r_off[0];
      end
      OP_LWL, OP_LWR: w_lwx = r_off;
      default: w_mis = (r_off != 2'd0);
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_mem_req   <= 1'b0;
      r_mem_addr  <= RESET_PC;
      r_op        <= 6'd0;
      r_off       <= 2'd0;
      r_dest      <= 5'd0;
      r_ld_we     <= 1'b0;
      r_wb_we     <= 1'b0;
      r_wb_link   <= 1'b0;
      r_wb_err    <= 1'b0;
      r_wb_reg    <= 5'd0;
      r_wb_data   <= RESET_PC;
      r_wb_lwx    <= 2'd0;
      r_pend_v    <= 1'b0;
      r_pend_we   <= 1'b0;
      r_pend_link <= 1'b0;
      r_pend_reg  <= 5'd0;
      r_pend_data <= 32'd0;
    end else begin
      r_wb_we   <= 1'b0;
      r_wb_link <= 1'b0;
      r_wb_err  <= 1'b0;
      if (w_load_done) begin
        r_wb_we   <= r_ld_we && (r_dest != 5'd0) && !w_mis;
        r_wb_err  <= w_mis;
        r_wb_reg  <= r_dest;
        r_wb_data <= w_ext;
        r_wb_lwx  <= w_lwx;
      end else if (r_pend_v) begin
        r_wb_we   <= r_pend_we;
        r_wb_link <= r_pend_link;
        r_wb_reg  <= r_pend_reg;
        r_wb_data <= r_pend_data;
        r_wb_lwx  <= 2'd0;
      end else if (w_acc_alu) begin
        r_wb_we   <= w_alu_we;
        r_wb_link <= bus.link_i;
        r_wb_reg  <= w_alu_reg;
        r_wb_data <= w_alu_data;
        r_wb_lwx  <= 2'd0;
      end

      // A non-load accepted while the writeback port is busy waits one slot.
      if (w_acc_alu && (w_load_done || r_pend_v)) begin
        r_pend_v    <= 1'b1;
        r_pend_we   <= w_alu_we;
        r_pend_link <= bus.link_i;
        r_pend_reg  <= w_alu_reg;
        r_pend_data <= w_alu_data;
      end else begin
        r_pend_v <= 1'b0;
      end

      if (w_acc_load) begin
        r_state    <= WAIT_MEM;
        r_mem_req  <= 1'b1;
        r_mem_addr <= {bus.aluResult_i[31:2], 2'b00};
        r_op       <= bus.aluCtrl_i;
        r_off      <= bus.aluResult_i[1:0];
        r_dest     <= bus.writeReg_i;
        r_ld_we    <= bus.regWrite_i;
      end else if (w_load_done) begin
        r_state   <= IDLE;
        r_mem_req <= 1'b0;
      end
    end
  end

  assign bus.stall_o     = w_stall;
  assign bus.memReq_o    = r_mem_req;
  assign bus.memAddr_o   = r_mem_addr;
  assign bus.regWrite3_o = r_wb_we;
  assign bus.writeReg_o  = r_wb_reg;
  assign bus.writeData_o = r_wb_data;
  assign bus.link3_o     = r_wb_link;
  assign bus.lwxCtrl_o   = r_wb_lwx;
  assign bus.addrErr_o   = r_wb_err;
endmodule
